// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the DMEM arbiter slice: memory geometry,
// arbiter FSM encoding and requester IDs.
package dmem_arb_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
  localparam int          DMEM_DEPTH     = 2048;
  localparam int          DMEM_IDX_W     = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the DMEM port.
// The arbiter uses the slave modport; the environment uses master.
interface dmem_arbiter_if #(
  parameter int IW = dmem_arb_pkg::DMEM_IDX_W
);

  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [31:0]   m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [31:0]   m0_rdata;
  logic          m0_err;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [31:0]   m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [31:0]   m1_rdata;
  logic          m1_err;

  logic          dm_w;
  logic          dm_r;
  logic [IW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output dm_w, dm_r, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  dm_w, dm_r, dm_addr, dm_wdata,
    output dm_rdata
  );

endinterface

// File: rtl/dmem_arbiter_xlate.sv
// Combinational byte-address to DMEM word-index translation with bad-address
// detection (below base, misaligned, or past the end of the data segment).
module dmem_addr_xlate
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int          DEPTH     = DMEM_DEPTH,
  localparam int         IW        = $clog2(DEPTH)
) (
  input  logic [31:0]   addr_i,
  output logic [IW-1:0] idx_o,
  output logic          bad_o
);

  logic [31:0] off;

  assign off   = addr_i - BASE_ADDR;
  assign idx_o = off[IW+1:2];

  // The word-offset compare uses all upper bits so wrap-around can't alias.
  assign bad_o = (addr_i < BASE_ADDR)
              || (off[1:0] != 2'b00)
              || ({2'b00, off[31:2]} >= 32'(DEPTH));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port DMEM between the CPU (m0) and
// the debug/loader port (m1), with lock hold. Optional stats: DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int          DEPTH     = DMEM_DEPTH
) (
  input  logic        clk_in,
  input  logic        reset,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0] m0_cnt,
  output logic [15:0] m1_cnt,
  output logic [15:0] err_cnt,
`endif
  dmem_arbiter_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  arb_state_e    state_q, state_d;
  logic          last_q;
  logic          grant;
  logic          win;
  logic          winWe;
  logic          winLock;
  logic [31:0]   winAddr;
  logic [31:0]   winWdata;
  logic [IW-1:0] idx;
  logic          bad;
  logic          gnt0, gnt1;
  logic          dmW, dmR;
  logic [IW-1:0] dmAddr, dmAddr_q;
  logic [31:0]   dmWdata, dmWdata_q;
  logic [31:0]   rdata_d;
  logic          rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  // Ties go to the requester that was not granted last; an owner excludes the other side.
  always_comb begin
    grant   = 1'b0;
    win     = REQ_CPU;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          grant = 1'b1;
          win   = ~last_q;
        end else if (bus.m0_req) begin
          grant = 1'b1;
          win   = REQ_CPU;
        end else if (bus.m1_req) begin
          grant = 1'b1;
          win   = REQ_DBG;
        end
      end
      OWN0: begin
        if (bus.m0_req) begin
          grant = 1'b1;
          win   = REQ_CPU;
        end
      end
      OWN1: begin
        if (bus.m1_req) begin
          grant = 1'b1;
          win   = REQ_DBG;
        end
      end
      default: ;
    endcase
    if (reset) grant = 1'b0;

    if (grant) begin
      state_d = winLock ? ((win == REQ_DBG) ? OWN1 : OWN0) : IDLE;
    end else if (state_q == OWN0 && !bus.m0_req && !bus.m0_lock) begin
      state_d = IDLE;
    end else if (state_q == OWN1 && !bus.m1_req && !bus.m1_lock) begin
      state_d = IDLE;
    end
  end

  assign winWe    = (win == REQ_DBG) ? bus.m1_we    : bus.m0_we;
  assign winLock  = (win == REQ_DBG) ? bus.m1_lock  : bus.m0_lock;
  assign winAddr  = (win == REQ_DBG) ? bus.m1_addr  : bus.m0_addr;
  assign winWdata = (win == REQ_DBG) ? bus.m1_wdata : bus.m0_wdata;

  dmem_addr_xlate #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_xlate (
    .addr_i (winAddr),
    .idx_o  (idx),
    .bad_o  (bad)
  );

  assign gnt0    = grant && (win == REQ_CPU);
  assign gnt1    = grant && (win == REQ_DBG);
  assign dmW     = grant && winWe && !bad;
  assign dmR     = grant && !winWe && !bad;
  assign dmAddr  = reset ? '0 : ((grant && !bad) ? idx : dmAddr_q);
  assign dmWdata = reset ? '0 : (grant ? winWdata : dmWdata_q);
  assign rdata_d = dmR ? bus.dm_rdata : 32'd0;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= REQ_DBG;
      dmAddr_q  <= '0;
      dmWdata_q <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      if (grant) last_q <= win;
      dmAddr_q  <= dmAddr;
      dmWdata_q <= dmWdata;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      err0_q    <= gnt0 && bad;
      err1_q    <= gnt1 && bad;
      rdata0_q  <= gnt0 ? rdata_d : 32'd0;
      rdata1_q  <= gnt1 ? rdata_d : 32'd0;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.dm_w      = dmW;
  assign bus.dm_r      = dmR;
  assign bus.dm_addr   = dmAddr;
  assign bus.dm_wdata  = dmWdata;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] m0Cnt_q, m1Cnt_q, errCnt_q;

  // Saturating event counters; a suppressed grant during reset never counts.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      m0Cnt_q  <= '0;
      m1Cnt_q  <= '0;
      errCnt_q <= '0;
    end else begin
      if (gnt0 && m0Cnt_q != 16'hFFFF) m0Cnt_q <= m0Cnt_q + 16'd1;
      if (gnt1 && m1Cnt_q != 16'hFFFF) m1Cnt_q <= m1Cnt_q + 16'd1;
      if (grant && bad && errCnt_q != 16'hFFFF) errCnt_q <= errCnt_q + 16'd1;
    end
  end

  assign m0_cnt  = m0Cnt_q;
  assign m1_cnt  = m1Cnt_q;
  assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   checkEn  = 1'b0;

  dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] m0_cnt, m1_cnt, err_cnt;
`endif

  dmem_arbiter dut (
    .clk_in  (clk_in),
    .reset   (reset),
`ifdef DMEM_ARB_STATS_EN
    .m0_cnt  (m0_cnt),
    .m1_cnt  (m1_cnt),
    .err_cnt (err_cnt),
`endif
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [31:0] envMem [0:DMEM_DEPTH-1];
  logic [31:0] refMem [0:DMEM_DEPTH-1];

  assign bus.dm_rdata = envMem[bus.dm_addr];

  always @(posedge clk_in) begin
    if (bus.dm_w === 1'b1) envMem[bus.dm_addr] <= bus.dm_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: owner -1 means nobody holds a lock.
  int          mOwner = -1;
  int          mLast  = 1;
  bit          eRv  [2];
  logic [31:0] eRd  [2];
  bit          eErr [2];
  logic [10:0] mDmAddr = '0;
  int          c0 = 0, c1 = 0, cE = 0;

  always @(negedge clk_in) begin : modelProc
    int          win, idx;
    bit          r [2];
    bit          l [2];
    bit          we, lk, bad;
    logic [31:0] a, wd;
    longint      off;
    if (checkEn) begin
      checkOutput("m0_rvalid", 32'(bus.m0_rvalid), 32'(eRv[0]));
      checkOutput("m1_rvalid", 32'(bus.m1_rvalid), 32'(eRv[1]));
      if (eRv[0]) begin
        checkOutput("m0_rdata", bus.m0_rdata, eRd[0]);
        checkOutput("m0_err", 32'(bus.m0_err), 32'(eErr[0]));
      end
      if (eRv[1]) begin
        checkOutput("m1_rdata", bus.m1_rdata, eRd[1]);
        checkOutput("m1_err", 32'(bus.m1_err), 32'(eErr[1]));
      end
`ifdef DMEM_ARB_STATS_EN
      checkOutput("m0_cnt", 32'(m0_cnt), 32'(c0));
      checkOutput("m1_cnt", 32'(m1_cnt), 32'(c1));
      checkOutput("err_cnt", 32'(err_cnt), 32'(cE));
`endif
      r[0] = bus.m0_req;  r[1] = bus.m1_req;
      l[0] = bus.m0_lock; l[1] = bus.m1_lock;
      win = -1;
      if (!reset) begin
        if (mOwner >= 0) begin
          if (r[mOwner]) win = mOwner;
        end else if (r[0] && r[1]) win = 1 - mLast;
        else if (r[0]) win = 0;
        else if (r[1]) win = 1;
      end
      we = 0; lk = 0; a = '0; wd = '0; bad = 0; idx = 0; off = 0;
      if (win == 0) begin
        we = bus.m0_we; lk = bus.m0_lock; a = bus.m0_addr; wd = bus.m0_wdata;
      end else if (win == 1) begin
        we = bus.m1_we; lk = bus.m1_lock; a = bus.m1_addr; wd = bus.m1_wdata;
      end
      if (win >= 0) begin
        off = longint'(a) - longint'(DMEM_BASE_ADDR);
        bad = (off < 0) || (off % 4 != 0) || (off / 4 >= DMEM_DEPTH);
        if (!bad) idx = int'(off / 4);
      end
      checkOutput("m0_gnt", 32'(bus.m0_gnt), 32'(win == 0));
      checkOutput("m1_gnt", 32'(bus.m1_gnt), 32'(win == 1));
      checkOutput("dm_w", 32'(bus.dm_w), 32'(win >= 0 && we && !bad));
      checkOutput("dm_r", 32'(bus.dm_r), 32'(win >= 0 && !we && !bad));
      if (reset) checkOutput("dm_addr", 32'(bus.dm_addr), 32'd0);
      else if (win >= 0 && !bad) checkOutput("dm_addr", 32'(bus.dm_addr), 32'(idx));
      else if (win < 0) checkOutput("dm_addr", 32'(bus.dm_addr), 32'(mDmAddr));
      if (win >= 0 && we && !bad) checkOutput("dm_wdata", bus.dm_wdata, wd);

      eRv[0] = 0; eRv[1] = 0; eErr[0] = 0; eErr[1] = 0; eRd[0] = '0; eRd[1] = '0;
      if (reset) begin
        mOwner = -1; mLast = 1; mDmAddr = '0; c0 = 0; c1 = 0; cE = 0;
      end else if (win >= 0) begin
        eRv[win]  = 1;
        eErr[win] = bad;
        eRd[win]  = (!we && !bad) ? refMem[idx] : 32'd0;
        if (we && !bad) refMem[idx] = wd;
        if (!bad) mDmAddr = 11'(idx);
        mOwner = lk ? win : -1;
        mLast  = win;
        if (win == 0 && c0 < 65535) c0++;
        if (win == 1 && c1 < 65535) c1++;
        if (bad && cE < 65535) cE++;
      end else if (mOwner >= 0 && !r[mOwner] && !l[mOwner]) begin
        mOwner = -1;
      end
    end
  end

  task automatic applyStimulus(input bit rst,
      input bit r0, input bit w0, input bit l0, input logic [31:0] a0, input logic [31:0] d0,
      input bit r1, input bit w1, input bit l1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk_in);
    #1;
    reset = rst;
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
    @(negedge clk_in);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] genAddr();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0) return DMEM_BASE_ADDR - 32'(4 * $urandom_range(1, 4));
    if (sel == 1) return DMEM_BASE_ADDR + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    if (sel == 2) return DMEM_BASE_ADDR + 32'h2000 + 32'(4 * $urandom_range(0, 15));
    if (sel == 3) return DMEM_BASE_ADDR + 32'(4 * $urandom_range(0, DMEM_DEPTH - 1));
    return DMEM_BASE_ADDR + 32'(4 * $urandom_range(0, 31));
  endfunction

  logic [31:0] badAddr [3];
  int          gntSeq  [4];
  int          expSeq  [4];

  initial begin
    logic [31:0] v, orig;
    bit          cr [2], cw [2], cl [2], lg [2];
    logic [31:0] ca [2], cd [2];
    bit          rst;

    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    for (int i = 0; i < DMEM_DEPTH; i++) begin
      v = $urandom;
      envMem[i] = v;
      refMem[i] = v;
    end
    envMem[2] = 32'hDEADBEEF;
    refMem[2] = 32'hDEADBEEF;

    @(posedge clk_in);
    #1;
    checkEn = 1'b1;
    @(negedge clk_in);
    checkOutput("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    checkOutput("rst_m1_rdata", bus.m1_rdata, 32'd0);
    checkOutput("rst_dm_w", 32'(bus.dm_w), 32'd0);
    checkOutput("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    checkOutput("rst_dm_wdata", bus.dm_wdata, 32'd0);

    applyStimulus(0, 1, 0, 0, 32'h1001_0008, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    checkOutput("rd_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    checkOutput("rd_dm_addr", 32'(bus.dm_addr), 32'd2);
    checkOutput("rd_dm_r", 32'(bus.dm_r), 32'd1);
    idleCycle();
    checkOutput("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    checkOutput("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_m0_err", 32'(bus.m0_err), 32'd0);

    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    expSeq[0] = 0; expSeq[1] = 1; expSeq[2] = 0; expSeq[3] = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h1001_0000, 32'd0, 1, 0, 0, 32'h1001_0004, 32'd0);
      gntSeq[i] = bus.m1_gnt ? 1 : (bus.m0_gnt ? 0 : -1);
      checkOutput("rr_order", 32'(gntSeq[i]), 32'(expSeq[i]));
      if (i > 0)
        checkOutput("rr_rvalid", 32'(gntSeq[i-1] == 1 ? bus.m1_rvalid : bus.m0_rvalid), 32'd1);
    end
    idleCycle();

    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1, 1, 1, 32'h1001_0010, 32'h12345678);
    checkOutput("lk_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    checkOutput("lk_dm_w", 32'(bus.dm_w), 32'd1);
    checkOutput("lk_dm_addr", 32'(bus.dm_addr), 32'd4);
    applyStimulus(0, 1, 0, 0, 32'h1001_0010, 32'd0, 0, 0, 1, 32'd0, 32'd0);
    checkOutput("lk_hold_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h1001_0010, 32'd0, 1, 0, 0, 32'h1001_0010, 32'd0);
    checkOutput("lk_rd_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    checkOutput("lk_rd_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'h1001_0010, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    checkOutput("lk_m1_rdata", bus.m1_rdata, 32'h12345678);
    checkOutput("lk_rel_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    idleCycle();
    checkOutput("lk_m0_rdata", bus.m0_rdata, 32'h12345678);

    badAddr[0] = 32'h1001_0001; badAddr[1] = 32'h1000_FFFC; badAddr[2] = 32'h1001_2000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, (i == 1), 0, badAddr[i], 32'hA5A5A5A5, 0, 0, 0, 32'd0, 32'd0);
      checkOutput("bad_m0_gnt", 32'(bus.m0_gnt), 32'd1);
      checkOutput("bad_dm_w", 32'(bus.dm_w), 32'd0);
      checkOutput("bad_dm_r", 32'(bus.dm_r), 32'd0);
      idleCycle();
      checkOutput("bad_m0_err", 32'(bus.m0_err), 32'd1);
      checkOutput("bad_m0_rdata", bus.m0_rdata, 32'd0);
    end
`ifdef DMEM_ARB_STATS_EN
    checkOutput("bad_err_cnt", 32'(err_cnt), 32'd3);
`endif

    orig = envMem[8];
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 1, 1, 1, 32'h1001_0020, ~orig);
    checkOutput("rstw_dm_w", 32'(bus.dm_w), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h1001_0000, 32'd0, 1, 0, 0, 32'h1001_0004, 32'd0);
    checkOutput("rstw_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    checkOutput("rstw_tie_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    idleCycle();
    checkOutput("rstw_mem", envMem[8], orig);

    for (int k = 0; k < 2; k++) begin
      cr[k] = 0; cw[k] = 0; cl[k] = 0; lg[k] = 0; ca[k] = '0; cd[k] = '0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(cr[k] && !lg[k])) begin
          cr[k] = ($urandom_range(0, 3) != 0);
          cw[k] = 1'($urandom_range(0, 1));
          cl[k] = ($urandom_range(0, 7) == 0);
          ca[k] = genAddr();
          cd[k] = $urandom;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(rst, cr[0], cw[0], cl[0], ca[0], cd[0], cr[1], cw[1], cl[1], ca[1], cd[1]);
      lg[0] = bus.m0_gnt;
      lg[1] = bus.m1_gnt;
    end
    idleCycle();

`ifdef DMEM_ARB_STATS_EN
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    for (int c = 0; c < 70000; c++)
      applyStimulus(0, 1, 0, 0, 32'h1001_0000, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    idleCycle();
    checkOutput("sat_m0_cnt", 32'(m0_cnt), 32'h0000FFFF);
    checkOutput("sat_m1_cnt", 32'(m1_cnt), 32'd0);
`endif

    idleCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
